// File: rtl/sev_seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Holds the hex-to-segment table and elaboration-time parameter checks.
package sev_seg_scan_ctrl_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low segments ordered g..a; the decimal point is handled separately.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  function automatic bit params_legal(input int num_digits, input int refresh_div,
                                      input int blank_cycles);
    int active;
    active = refresh_div - blank_cycles;
    return (num_digits >= 2) && (num_digits <= 8) && (blank_cycles >= 0) &&
           (active > 0) && ((active % 16) == 0);
  endfunction

endpackage

// File: rtl/sev_seg_decoder.sv
// Hex nibble to active-low seven-segment pattern; dp output is always off.
module sev_seg_decoder
  import sev_seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg_n
);

  assign seg_n = {1'b1, hex_to_seg(nibble)};

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment driver with PWM dimming,
// leading-zero suppression and frame-synchronous double-buffered updates.
module sev_seg_scan_ctrl
  import sev_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int SUB = (REFRESH_DIV - BLANK_CYCLES) / 16;
  localparam int CW  = $clog2(REFRESH_DIV);
  localparam int IW  = $clog2(NUM_DIGITS);
  localparam int SW  = (SUB > 1) ? $clog2(SUB) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(SUB - 1);

  if (!params_legal(NUM_DIGITS, REFRESH_DIV, BLANK_CYCLES)) begin : g_bad_params
    $error("sev_seg_scan_ctrl: illegal NUM_DIGITS/REFRESH_DIV/BLANK_CYCLES");
  end

  logic [CW-1:0]             cnt_reg;
  logic [IW-1:0]             idx_reg;
  logic [SW-1:0]             sub_cnt_reg;
  logic [3:0]                sub_idx_reg;
  logic [3:0]                bright_reg;
  logic [4*NUM_DIGITS-1:0]   shadow_digits_reg, pend_digits_reg;
  logic [NUM_DIGITS-1:0]     shadow_dp_reg, pend_dp_reg;
  logic [NUM_DIGITS-1:0]     shadow_blank_reg, pend_blank_reg;
  logic                      shadow_valid_reg;
  logic                      pending_reg;
  logic                      frame_done_reg;
  logic [7:0]                seg_n_reg, seg_n_next;
  logic [NUM_DIGITS-1:0]     an_n_reg, an_n_next;

  logic                      slot_wrap, frame_boundary, in_active, digit_lit;
  logic [3:0]                eff_bright, cur_nibble;
  logic [7:0]                dec_seg;
  logic [NUM_DIGITS-1:0]     lead_zero;

  // A digit is a leading zero when it and every more-significant nibble are zero.
  assign lead_zero[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
    assign lead_zero[gi] = ~|shadow_digits_reg[4*NUM_DIGITS-1:4*gi];
  end

  assign cur_nibble = shadow_digits_reg[{idx_reg, 2'b00} +: 4];

  sev_seg_decoder u_decoder (
    .nibble (cur_nibble),
    .seg_n  (dec_seg)
  );

  always_comb begin
    slot_wrap      = (cnt_reg == CNT_LAST);
    frame_boundary = slot_wrap && (idx_reg == IDX_LAST);
    in_active      = (cnt_reg >= CNT_BLANK);
    // Brightness is latched on the first cycle of a slot, so use it live there.
    eff_bright     = (cnt_reg == '0) ? brightness : bright_reg;
    digit_lit      = shadow_valid_reg && !shadow_blank_reg[idx_reg] &&
                     !(lz_suppress && lead_zero[idx_reg]) &&
                     in_active && (sub_idx_reg <= eff_bright);
    seg_n_next     = SEG_OFF;
    an_n_next      = '1;
    if (digit_lit) begin
      seg_n_next    = dec_seg;
      seg_n_next[7] = ~shadow_dp_reg[idx_reg];
      an_n_next     = ~(NUM_DIGITS'(1) << idx_reg);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg     <= '0;
      idx_reg     <= '0;
      sub_cnt_reg <= '0;
      sub_idx_reg <= '0;
      bright_reg  <= '0;
    end else begin
      if (cnt_reg == '0) begin
        bright_reg <= brightness;
      end
      if (slot_wrap) begin
        cnt_reg     <= '0;
        idx_reg     <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
        sub_cnt_reg <= '0;
        sub_idx_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
        if (in_active) begin
          if (sub_cnt_reg == SUB_LAST) begin
            sub_cnt_reg <= '0;
            sub_idx_reg <= sub_idx_reg + 4'd1;
          end else begin
            sub_cnt_reg <= sub_cnt_reg + SW'(1);
          end
        end
      end
    end
  end

  // Loads coinciding with the frame boundary bypass the pending buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_digits_reg <= '0;
      shadow_dp_reg     <= '0;
      shadow_blank_reg  <= '0;
      shadow_valid_reg  <= 1'b0;
      pend_digits_reg   <= '0;
      pend_dp_reg       <= '0;
      pend_blank_reg    <= '0;
      pending_reg       <= 1'b0;
      frame_done_reg    <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (frame_boundary && (load || pending_reg)) begin
        shadow_digits_reg <= load ? digits_in : pend_digits_reg;
        shadow_dp_reg     <= load ? dp_in : pend_dp_reg;
        shadow_blank_reg  <= load ? blank_in : pend_blank_reg;
        shadow_valid_reg  <= 1'b1;
        pending_reg       <= 1'b0;
        frame_done_reg    <= 1'b1;
      end else if (load) begin
        pend_digits_reg <= digits_in;
        pend_dp_reg     <= dp_in;
        pend_blank_reg  <= blank_in;
        pending_reg     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_n_reg <= SEG_OFF;
      an_n_reg  <= '1;
    end else begin
      seg_n_reg <= seg_n_next;
      an_n_reg  <= an_n_next;
    end
  end

  assign seg_n      = seg_n_reg;
  assign an_n       = an_n_reg;
  assign frame_done = frame_done_reg;
  assign pending    = pending_reg;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Self-checking bench: per-cycle comparison against a frame-arithmetic model,
// directed frame measurements with literal expectations, then random traffic.
module tb_sev_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 48;
  localparam int BC = 16;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        reset;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  brightness = '0;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;
  logic        pending;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  sev_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lz_suppress(lz_suppress),
    .brightness (brightness),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done),
    .pending    (pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time position derived from an edge count since reset.
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          m_steps, m_bright;
  bit          m_valid, m_pend;
  logic [15:0] m_sh_d, m_pd_d;
  logic [3:0]  m_sh_dp, m_sh_b, m_pd_dp, m_pd_b;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic        e_fd, e_pend;

  always @(posedge clk or posedge reset) begin
    int pos, dig, br, nib;
    bit vis, lit;
    if (reset) begin
      m_steps = 0; m_bright = 0; m_valid = 0; m_pend = 0;
      m_sh_d = '0; m_pd_d = '0; m_sh_dp = '0; m_sh_b = '0; m_pd_dp = '0; m_pd_b = '0;
      e_an = 4'hF; e_seg = 8'hFF; e_fd = 1'b0; e_pend = 1'b0;
    end else begin
      pos = m_steps % RD;
      dig = (m_steps / RD) % ND;
      br  = (pos == 0) ? int'(brightness) : m_bright;
      if (pos == 0) m_bright = int'(brightness);
      nib = int'((m_sh_d >> (4 * dig)) & 16'hF);
      vis = m_valid && !m_sh_b[dig] &&
            !(lz_suppress && dig != 0 && (m_sh_d >> (4 * dig)) == 16'h0);
      lit = vis && pos >= BC && ((pos - BC) / ((RD - BC) / 16)) <= br;
      e_an  = lit ? ~(4'b0001 << dig) : 4'hF;
      e_seg = lit ? {~m_sh_dp[dig], hex_tab[nib]} : 8'hFF;
      e_fd  = 1'b0;
      if ((m_steps % FRAME) == FRAME - 1 && (load || m_pend)) begin
        m_sh_d  = load ? digits_in : m_pd_d;
        m_sh_dp = load ? dp_in : m_pd_dp;
        m_sh_b  = load ? blank_in : m_pd_b;
        m_valid = 1; m_pend = 0; e_fd = 1'b1;
      end else if (load) begin
        m_pd_d = digits_in; m_pd_dp = dp_in; m_pd_b = blank_in; m_pend = 1;
      end
      e_pend = m_pend;
      m_steps++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("an_n", an_n, e_an);
      chk("seg_n", seg_n, e_seg);
      chk("frame_done", frame_done, e_fd);
      chk("pending", pending, e_pend);
    end
  end

  task automatic load_cmd(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                          input logic lz, input logic [3:0] br);
    @(negedge clk);
    digits_in = d; dp_in = dp; blank_in = bl; lz_suppress = lz; brightness = br;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (frame_done !== 1'b1 && waited < FRAME + 10);
    chk("frame_done_seen", frame_done, 1'b1);
  endtask

  // Call right after frame_done is seen: next negedge shows slot 0 position 0.
  task automatic measure_frame(input logic [15:0] ean, input logic [31:0] eseg,
                               input int l0, input int l1, input int l2, input int l3);
    int lits[4];
    int lit_c, good_c, early_c;
    lits = '{l0, l1, l2, l3};
    for (int s = 0; s < ND; s++) begin
      lit_c = 0; good_c = 0; early_c = 0;
      for (int p = 0; p < RD; p++) begin
        @(negedge clk);
        if (an_n !== 4'hF) begin
          lit_c++;
          if (p < BC) early_c++;
        end
        if (an_n === ean[4*s +: 4] && seg_n === eseg[8*s +: 8]) good_c++;
      end
      $display("slot %0d: lit %0d good %0d (want %0d)", s, lit_c, good_c, lits[s]);
      chk("slot_lit", lit_c, lits[s]);
      chk("slot_good", good_c, lits[s]);
      chk("slot_guard", early_c, 0);
    end
  endtask

  initial begin
    int w, dark_viol;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_an", an_n, 4'hF);
    chk("rst_seg", seg_n, 8'hFF);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_pend", pending, 1'b0);
    reset = 1'b0;

    dark_viol = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (an_n !== 4'hF || seg_n !== 8'hFF) dark_viol++;
    end
    chk("idle_dark", dark_viol, 0);

    load_cmd(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd15);
    wait_fd(w);
    measure_frame(16'h7BDE, 32'hF9A4_888E, 32, 32, 32, 32);

    load_cmd(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd0);
    wait_fd(w);
    measure_frame(16'h7BDE, 32'hF9A4_888E, 2, 2, 2, 2);

    load_cmd(16'h12AF, 4'h0, 4'b0010, 1'b0, 4'd3);
    wait_fd(w);
    measure_frame(16'h7B0E, 32'hF9A4_888E, 8, 0, 8, 8);

    load_cmd(16'h0050, 4'b1000, 4'h0, 1'b1, 4'd15);
    wait_fd(w);
    measure_frame(16'h00DE, 32'h0000_92C0, 32, 32, 0, 0);

    load_cmd(16'h0050, 4'b0001, 4'h0, 1'b1, 4'd1);
    wait_fd(w);
    measure_frame(16'h00DE, 32'h0000_9240, 4, 4, 0, 0);

    // Load on the frame-boundary cycle itself.
    load_cmd(16'h0000, 4'h0, 4'h0, 1'b0, 4'd7);
    wait_fd(w);
    repeat (FRAME - 1) @(negedge clk);
    digits_in = 16'h3C7E; dp_in = '0; blank_in = '0; lz_suppress = 1'b0; brightness = 4'd7;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("bnd_fd", frame_done, 1'b1);
    chk("bnd_pend", pending, 1'b0);
    measure_frame(16'h7BDE, 32'hB0C6_F886, 16, 16, 16, 16);

    // Two loads in one frame: last wins.
    repeat (20) @(negedge clk);
    load_cmd(16'h1111, 4'h0, 4'h0, 1'b0, 4'd15);
    repeat (30) @(negedge clk);
    load_cmd(16'h4321, 4'h0, 4'h0, 1'b0, 4'd15);
    chk("two_pend", pending, 1'b1);
    wait_fd(w);
    measure_frame(16'h7BDE, 32'h99B0_A4F9, 32, 32, 32, 32);

    // Reset in the middle of slot 2.
    load_cmd(16'h8888, 4'hF, 4'h0, 1'b0, 4'd15);
    wait_fd(w);
    repeat (2 * RD + 20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_an", an_n, 4'hF);
    chk("midrst_seg", seg_n, 8'hFF);
    chk("midrst_fd", frame_done, 1'b0);
    chk("midrst_pend", pending, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    load_cmd(16'h0000, 4'h0, 4'h0, 1'b0, 4'd15);
    wait_fd(w);
    chk("restart_align", 2 + w, FRAME);
    measure_frame(16'h7BDE, 32'hC0C0_C0C0, 32, 32, 32, 32);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0: digits_in = 16'($urandom);
        1: digits_in = 16'($urandom) & 16'h00FF;
        2: digits_in = 16'($urandom) & 16'h000F;
        default: digits_in = 16'($urandom) & 16'h0F0F;
      endcase
      dp_in = 4'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      brightness = 4'($urandom);
      if ((i % 500) == 0) lz_suppress = ~lz_suppress;
    end
    @(negedge clk);
    load = 1'b0;
    repeat (FRAME + 5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sev_seg_scan_ctrl.md
# sev_seg_scan_ctrl

Parametrised time-multiplexed driver for a bank of common-anode seven-segment digits with hex decoding, decimal points, per-digit blanking, leading-zero suppression, 16-level PWM brightness and tear-free frame-synchronous updates. It sits between the datapath that produces displayable nibbles (adder/subtractor results, counters) and the board's segment/anode pins, replacing fixed-width scan logic that has no prescaler or update control.

## Interface
Parameters:
- NUM_DIGITS, 8, number of multiplexed digits; legal range 2..8.
- REFRESH_DIV, 100000, clk cycles per digit slot.
- BLANK_CYCLES, 16, anti-ghosting guard at slot start; REFRESH_DIV - BLANK_CYCLES must be a nonzero multiple of 16.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- load  in  1  single-cycle strobe; captures digits_in, dp_in, blank_in.
- digits_in  in  4*NUM_DIGITS  hex nibbles; nibble i = [4i+3:4i], digit 0 rightmost.
- dp_in  in  NUM_DIGITS  1 = decimal point lit on digit i.
- blank_in  in  NUM_DIGITS  1 = digit i forced dark (dp also dark).
- lz_suppress  in  1  1 = blank leading zeros; sampled live.
- brightness  in  4  on-time = (brightness+1)/16 of active window; sampled at slot start.
- seg_n  out  8  active-low; [6:0] = g..a, [7] = dp.
- an_n  out  NUM_DIGITS  active-low digit enables, one-hot-low or all ones.
- frame_done  out  1  one-cycle pulse when a frame boundary commits shadow data.
- pending  out  1  1 = loaded data waiting for the next frame boundary.

## Operation
- Reset values: seg_n all ones, an_n all ones, frame_done 0, pending 0, shadow/pending data 0, digit index 0, slot counter 0.
- Slot counter counts 0..REFRESH_DIV-1; on wrap the digit index advances 0,1,..,NUM_DIGITS-1,0. Frame boundary = the wrap cycle of digit NUM_DIGITS-1.
- Within a slot: counter < BLANK_CYCLES -> an_n all ones, seg_n all ones. Active window split into 16 sub-periods of SUB = (REFRESH_DIV-BLANK_CYCLES)/16 cycles; digit lit during sub-periods 0..brightness, dark otherwise.
- Decode: 0-F standard hex, e.g. 0 -> seg_n[6:0]=7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110.
- Digit i is dark if blank_in-shadow[i], or if lz_suppress and i != 0 and all shadow nibbles NUM_DIGITS-1..i are zero. Digit 0 always shows when not blanked. A dp on a suppressed digit is also dark.
- Update handshake: load copies inputs to pending register and sets pending. At frame boundary, if pending, pending register -> shadow, pending clears, frame_done pulses. Display only ever reads shadow.
- Simultaneous load and frame boundary: incoming load data goes straight to shadow, pending ends 0, frame_done pulses.
- A second load before the boundary overwrites the pending register (last wins).
- Reset mid-operation: all outputs return to reset values immediately, no partial frame committed.

## Timing
- seg_n and an_n are registered: one clk latency from counter/index state; both change in the same cycle, never a cycle with an_n lit and stale seg_n.
- load -> display change: at most NUM_DIGITS*REFRESH_DIV + 1 cycles.
- frame_done asserts the cycle after the boundary clock edge, for exactly one cycle.
- Full frame period NUM_DIGITS*REFRESH_DIV cycles; each digit lit at most (brightness+1)*SUB cycles per slot.

## Structure
- Shared package: segment encodings per hex value, SEG_OFF = 8'hFF, parameter-legality checks.
- One sub-module: the team's existing sev_seg_decoder (4-bit in, 8-bit active-low out), dp bit overridden in this block.
- Prescaler, PWM sub-counter, index, shadow/pending registers and suppression logic live in the top.

## Test plan
Parameters NUM_DIGITS=4, REFRESH_DIV=48, BLANK_CYCLES=16 (SUB=2).
- Reset, no load -> an_n=4'b1111 and seg_n=8'hFF until load is applied; digits then show 0 after commit.
- load digits_in=16'h12AF, brightness=15 -> after frame_done, slot 0 shows F (seg_n=8'h8E) with an_n=4'b1110 for cycles 16..47, dark 0..15; slots 1..3 show A, 2, 1.
- brightness=0 -> each digit lit exactly 2 cycles per 48-cycle slot.
- digits_in=16'h0050, lz_suppress=1 -> digits 3,2 dark, digit 1 shows 5, digit 0 shows 0; dp_in=4'b1000 -> digit 3 dp still dark.
- load asserted on frame-boundary cycle -> shadow updated that edge, pending=0, frame_done one pulse; two loads mid-frame -> only second value displayed, pending=1 until boundary.
- reset asserted mid-slot 2 -> outputs all ones same cycle; after release scan restarts at digit 0, shadow=0.
